moore_seq_generator: RTL and testbench
======================================

# moore_seq_generator

Serial pattern transmitter, the sending end of the non-overlapping Moore sequence detector link. On a start request it emits a fixed PAT_LEN-bit pattern (default 11011) MSB-first on a single-bit line. The pattern is repeated a programmable number of times, with a programmable number of idle-zero cycles between repetitions. The block drives detector stimulus and loopback checks, and serves as the pattern source in serial test links.

## Interface
- PAT_LEN, 5: pattern length in bits, 2..16.
- PATTERN, 5'b11011: pattern value; bit PAT_LEN-1 is sent first.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- count  input  8  number of pattern repetitions; latched when start is accepted.
- gap  input  4  idle-zero cycles between repetitions; latched when start is accepted.
- dout  output  1  serial data; 0 whenever not in SEND.
- dout_valid  output  1  high while a pattern bit is on dout.
- frame_end  output  1  high with the last bit of each repetition.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a request.

## Operation
- All outputs are Moore outputs, decoded from registered state and counters only. There is no combinational path from any input to any output.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 with count≠0: latch count and gap, set bit_idx=0 and rep_left=count, go to SEND.
  - start=1 with count=0: go to DONE.
  - start=0: stay in IDLE.
- SEND:
  - dout=PATTERN[PAT_LEN-1-bit_idx], dout_valid=1.
  - If bit_idx<PAT_LEN-1: increment bit_idx and stay in SEND.
  - If bit_idx=PAT_LEN-1: frame_end=1 and decrement rep_left. Then:
    - rep_left was 1: go to DONE.
    - else if gap_l=0: go to SEND with bit_idx=0 (back-to-back repetitions).
    - else: load gap_cnt=gap_l and go to GAP.
- GAP:
  - dout=0, dout_valid=0.
  - Decrement gap_cnt each cycle. When gap_cnt reaches 1, set bit_idx=0 and go to SEND.
  - The line therefore holds exactly gap_l zero cycles.
- DONE: done=1, busy=1, dout=0. Unconditional transition to IDLE.
- start is ignored in SEND, GAP and DONE. It is neither queued nor sampled there.
- Counter widths:
  - bit_idx is $clog2(PAT_LEN) bits.
  - rep_left is 8 bits.
  - gap_cnt is 4 bits.
  - No counter wraps; every transition is decided before a counter would underflow.
- count and gap are captured once per request. Changes to either input mid-request have no effect.

## Timing
- Reset values: state=IDLE, dout=0, dout_valid=0, frame_end=0, busy=0, done=0, all counters 0.
- Reset asserted mid-operation (any state): all outputs reach their reset values immediately (asynchronous). The request is abandoned and no done pulse is produced.
- Start latency: start is sampled high at edge k. The first pattern bit is on dout in the cycle after edge k.
- Request duration, count=N, gap=G, in cycles after the start edge:
  - N·PAT_LEN cycles of SEND.
  - (N-1)·G cycles of GAP.
  - 1 cycle of DONE.
  - busy is high for exactly this total.
- count=0: DONE occupies the single cycle after the start edge. busy and done are high for that one cycle; dout_valid never rises.
- Back-to-back requests: the earliest next start is sampled in the first IDLE cycle after DONE. The minimum turnaround is therefore one cycle of busy=0.

## Structure
- Package moore_seq_pkg holds:
  - the FSM state enum, 2-bit encoding: IDLE=0, SEND=1, GAP=2, DONE=3;
  - the default PATTERN and PAT_LEN constants, shared with the detector testbench.
- The module is flat; no sub-module is warranted. It is one state register block, one next-state/counter block and one output decode.

## Test plan
- Single repetition: count=1, gap=0, start pulsed once → dout = 1,1,0,1,1 on five consecutive cycles with dout_valid=1; frame_end on the 5th bit; done on the 6th cycle; busy high for 6 cycles.
- Gap between repetitions: count=2, gap=3 → dout = 11011 000 11011; dout_valid low during the three 0s; frame_end twice; done once; 14 busy cycles.
- Zero repetitions: count=0 → busy=1 and done=1 for one cycle; dout_valid never high.
- Start while busy: count=2, gap=2, with start re-pulsed during SEND and during GAP → identical output to a single request; no second done.
- Reset mid-frame: assert reset after the 3rd bit → dout, busy and done are 0 immediately; after release, a fresh start sends the full pattern from its first bit.
- Loopback: count=3, gap=0, dout fed to the detector → detector y pulses exactly 3 times, each one cycle after the corresponding frame_end.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// ----------------------------------------------------------------------------
// moore_seq_pkg
// Shared definitions for the serial pattern generator and its matching
// non-overlapping Moore detector: FSM state encoding and the default pattern.
// ----------------------------------------------------------------------------
package moore_seq_pkg;

    // 2-bit state encoding, fixed so external tools can decode it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default pattern; MSB goes on the line first.
    localparam int                       DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0]   DEF_PATTERN = 5'b11011;

endpackage

// File: rtl/moore_seq_generator.sv
// ----------------------------------------------------------------------------
// moore_seq_generator
// Serial pattern transmitter. On an accepted start it sends PATTERN
// MSB-first, repeated 'count' times with 'gap' zero cycles between
// repetitions, then pulses done for one cycle.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   request, sampled only in IDLE
//   count[7:0]  in   repetitions, latched on accepted start
//   gap[3:0]    in   zero cycles between repetitions, latched on accepted start
//   dout        out  serial data (0 outside SEND)
//   dout_valid  out  high while a pattern bit is on dout
//   frame_end   out  high with the last bit of each repetition
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at end of a request
//
// All outputs decode registered state/counters only (pure Moore).
// ----------------------------------------------------------------------------
module moore_seq_generator
    import moore_seq_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] count,
    input  logic [3:0] gap,
    output logic       dout,
    output logic       dout_valid,
    output logic       frame_end,
    output logic       busy,
    output logic       done
);

    localparam int               IDX_W    = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [7:0]        rep_left_q, rep_left_d;
    logic [3:0]        gap_l_q, gap_l_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            rep_left_q <= '0;
            gap_l_q    <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            rep_left_q <= rep_left_d;
            gap_l_q    <= gap_l_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        rep_left_d = rep_left_q;
        gap_l_d    = gap_l_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != 8'd0) begin
                        rep_left_d = count;
                        gap_l_d    = gap;
                        bit_idx_d  = '0;
                        state_d    = SEND;
                    end else begin
                        state_d    = DONE;
                    end
                end
            end

            SEND: begin
                if (bit_idx_q != LAST_IDX) begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end else begin
                    rep_left_d = rep_left_q - 8'd1;
                    // Decide on the pre-decrement value so rep_left never wraps.
                    if (rep_left_q == 8'd1) begin
                        state_d = DONE;
                    end else if (gap_l_q == 4'd0) begin
                        bit_idx_d = '0;
                    end else begin
                        gap_cnt_d = gap_l_q;
                        state_d   = GAP;
                    end
                end
            end

            GAP: begin
                // Entered with gap_l, leaves after the cycle at 1: gap_l zero cycles.
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd1) begin
                    bit_idx_d = '0;
                    state_d   = SEND;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode
    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        frame_end  = 1'b0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        if (state_q == SEND) begin
            dout       = PATTERN[LAST_IDX - bit_idx_q];
            dout_valid = 1'b1;
            frame_end  = (bit_idx_q == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_moore_seq_generator.sv
module tb_moore_seq_generator;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] count;
    logic [3:0] gap;
    logic       dout;
    logic       dout_valid;
    logic       frame_end;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    moore_seq_generator dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .gap        (gap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_end  (frame_end),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-overlapping Moore detector for 11011 on the loopback path.
    typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5} dst_t;
    dst_t det_q;
    logic det_y;

    always @(posedge clk or posedge reset) begin
        if (reset) det_q <= D0;
        else begin
            case (det_q)
                D0: det_q <= dout ? D1 : D0;
                D1: det_q <= dout ? D2 : D0;
                D2: det_q <= dout ? D2 : D3;
                D3: det_q <= dout ? D4 : D0;
                D4: det_q <= dout ? D5 : D0;
                D5: det_q <= dout ? D1 : D0;
                default: det_q <= D0;
            endcase
        end
    end
    assign det_y = (det_q == D5);

    typedef struct {
        logic [7:0] cnt;
        logic [3:0] gp;
        bit         repulse;
        string      e_dout;
        string      e_vld;
        string      e_fe;
        string      e_done;
    } vec_t;

    vec_t vecs[7];

    string tr_dout, tr_vld, tr_fe, tr_done, tr_y;

    task automatic chk_s(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle. Returns at the negedge of
    // the first cycle with busy low. Traces hold one char per busy cycle.
    task automatic run_req(input logic [7:0] c, input logic [3:0] g, input bit repulse);
        int n;
        start = 1'b1;
        count = c;
        gap   = g;
        @(negedge clk);
        start = 1'b0;
        tr_dout = ""; tr_vld = ""; tr_fe = ""; tr_done = ""; tr_y = "";
        n = 0;
        while (busy) begin
            if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
                break;
            end
            tr_dout = {tr_dout, dout       ? "1" : "0"};
            tr_vld  = {tr_vld,  dout_valid ? "1" : "0"};
            tr_fe   = {tr_fe,   frame_end  ? "1" : "0"};
            tr_done = {tr_done, done       ? "1" : "0"};
            tr_y    = {tr_y,    det_y      ? "1" : "0"};
            if (repulse && (n == 2 || n == 6)) begin
                start = 1'b1; count = 8'd7; gap = 4'd9;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd1, 4'd0, 1'b0, "110110", "111110", "000010", "000001"};
        vecs[1] = '{8'd2, 4'd3, 1'b0, "11011000110110", "11111000111110",
                    "00001000000010", "00000000000001"};
        vecs[2] = '{8'd0, 4'd5, 1'b0, "0", "0", "0", "1"};
        vecs[3] = '{8'd2, 4'd0, 1'b0, "11011110110", "11111111110",
                    "00001000010", "00000000001"};
        vecs[4] = '{8'd1, 4'd5, 1'b0, "110110", "111110", "000010", "000001"};
        vecs[5] = '{8'd3, 4'd1, 1'b0, "110110110110110110", "111110111110111110",
                    "000010000010000010", "000000000000000001"};
        // start re-pulsed in SEND and GAP with changed count/gap: ignored
        vecs[6] = '{8'd2, 4'd2, 1'b1, "1101100110110", "1111100111110",
                    "0000100000010", "0000000000001"};

        reset = 1'b1;
        start = 1'b0;
        count = 8'd0;
        gap   = 4'd0;
        repeat (2) @(negedge clk);
        chk_b("rst dout",       dout,       1'b0);
        chk_b("rst dout_valid", dout_valid, 1'b0);
        chk_b("rst frame_end",  frame_end,  1'b0);
        chk_b("rst busy",       busy,       1'b0);
        chk_b("rst done",       done,       1'b0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].cnt, vecs[i].gp, vecs[i].repulse);
            chk_s($sformatf("v%0d dout", i),       tr_dout, vecs[i].e_dout);
            chk_s($sformatf("v%0d dout_valid", i), tr_vld,  vecs[i].e_vld);
            chk_s($sformatf("v%0d frame_end", i),  tr_fe,   vecs[i].e_fe);
            chk_s($sformatf("v%0d done", i),       tr_done, vecs[i].e_done);
        end

        // Reset in the middle of a frame
        start = 1'b1; count = 8'd1; gap = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk_b("mid busy before reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk_b("async dout",       dout,       1'b0);
        chk_b("async dout_valid", dout_valid, 1'b0);
        chk_b("async busy",       busy,       1'b0);
        chk_b("async done",       done,       1'b0);
        @(negedge clk);
        chk_b("held done", done, 1'b0);
        chk_b("held busy", busy, 1'b0);
        reset = 1'b0;
        run_req(8'd1, 4'd0, 1'b0);
        chk_s("post-reset dout", tr_dout, "110110");
        chk_s("post-reset done", tr_done, "000001");

        // Loopback into the detector, back-to-back repetitions
        run_req(8'd3, 4'd0, 1'b0);
        chk_s("loop dout",      tr_dout, "1101111011110110");
        chk_s("loop frame_end", tr_fe,   "0000100001000010");
        chk_s("loop det_y",     tr_y,    "0000010000100001");
        chk_b("idle after loop", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
